// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared definitions for the 5-stage pipeline control slice.
//   state_t               debug/run FSM encoding (visible on state_out)
//   FWD_REG/FWD_WB/FWD_MEM ALU operand forwarding select encoding
//   REG_ADDR_BITS_DEFAULT default register-file address width
package pipeline_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  localparam int REG_ADDR_BITS_DEFAULT = 5;

endpackage

// File: rtl/pipeline_fwd_unit.sv
// pipeline_fwd_unit: combinational EX-stage operand forwarding compare.
// Ports:
//   ex_rs_addr, ex_rt_addr     source registers of the instruction in EX
//   mem_w_addr, mem_reg_write  destination / write flag of the instruction in MEM
//   wb_w_addr, wb_reg_write    destination / write flag of the instruction in WB
//   fwd_a_sel, fwd_b_sel       operand selects (FWD_REG / FWD_WB / FWD_MEM)
module pipeline_fwd_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_BITS = REG_ADDR_BITS_DEFAULT
) (
  input  logic [REG_ADDR_BITS-1:0] ex_rs_addr,
  input  logic [REG_ADDR_BITS-1:0] ex_rt_addr,
  input  logic [REG_ADDR_BITS-1:0] mem_w_addr,
  input  logic                     mem_reg_write,
  input  logic [REG_ADDR_BITS-1:0] wb_w_addr,
  input  logic                     wb_reg_write,
  output logic [1:0]               fwd_a_sel,
  output logic [1:0]               fwd_b_sel
);

  // The younger result (MEM) wins over the older one (WB); $0 is never forwarded.
  function automatic logic [1:0] fwd_pick(
    input logic [REG_ADDR_BITS-1:0] src,
    input logic [REG_ADDR_BITS-1:0] m_addr,
    input logic                     m_we,
    input logic [REG_ADDR_BITS-1:0] w_addr,
    input logic                     w_we
  );
    if (m_we && (m_addr != '0) && (m_addr == src))
      return FWD_MEM;
    else if (w_we && (w_addr != '0) && (w_addr == src))
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

  assign fwd_a_sel = fwd_pick(ex_rs_addr, mem_w_addr, mem_reg_write, wb_w_addr, wb_reg_write);
  assign fwd_b_sel = fwd_pick(ex_rt_addr, mem_w_addr, mem_reg_write, wb_w_addr, wb_reg_write);

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: control/hazard block for the 5-stage pipeline (IF ID EX MEM WB).
// Drives every stage-register enable and flush through a run/step/halt FSM,
// detects data hazards, resolves branch flushes, and keeps saturating
// cycle and stall counters.
// Build option: define PIPELINE_FWD_EN for EX/MEM and MEM/WB forwarding with
// load-use stalls only; without it forwarding selects are tied to 0 and the
// block fully interlocks on any EX/MEM destination match.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   run, step                     free-run level, single-step pulse
//   id_halt                       HALT decoded in ID
//   id_rs_addr, id_rt_addr        ID sources
//   ex_rs_addr, ex_rt_addr        EX sources
//   ex_mem_read, ex_w_addr, ex_reg_write   EX load flag / destination / write
//   mem_w_addr, mem_reg_write     MEM destination / write
//   wb_w_addr, wb_reg_write       WB destination / write
//   branch_taken                  branch resolved taken in MEM
//   pc_enable, if_id_enable, stage_enable  register enables
//   if_id_flush, id_ex_flush, ex_mem_flush bubble inserts
//   fwd_a_sel, fwd_b_sel          ALU operand forwarding selects
//   halted, state_out             FSM status
//   cycle_count, stall_count      saturating counters
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_BITS = REG_ADDR_BITS_DEFAULT,
  parameter int CNT_WIDTH     = 32,
  parameter int DRAIN_CYCLES  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic                     step,
  input  logic                     id_halt,
  input  logic [REG_ADDR_BITS-1:0] id_rs_addr,
  input  logic [REG_ADDR_BITS-1:0] id_rt_addr,
  input  logic [REG_ADDR_BITS-1:0] ex_rs_addr,
  input  logic [REG_ADDR_BITS-1:0] ex_rt_addr,
  input  logic                     ex_mem_read,
  input  logic [REG_ADDR_BITS-1:0] ex_w_addr,
  input  logic                     ex_reg_write,
  input  logic [REG_ADDR_BITS-1:0] mem_w_addr,
  input  logic                     mem_reg_write,
  input  logic [REG_ADDR_BITS-1:0] wb_w_addr,
  input  logic                     wb_reg_write,
  input  logic                     branch_taken,
  output logic                     pc_enable,
  output logic                     if_id_enable,
  output logic                     stage_enable,
  output logic                     if_id_flush,
  output logic                     id_ex_flush,
  output logic                     ex_mem_flush,
  output logic [1:0]               fwd_a_sel,
  output logic [1:0]               fwd_b_sel,
  output logic                     halted,
  output logic [2:0]               state_out,
  output logic [CNT_WIDTH-1:0]     cycle_count,
  output logic [CNT_WIDTH-1:0]     stall_count
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_t               state_p0, state_d;
  logic [DCW-1:0]       drain_cnt_p0;
  logic [CNT_WIDTH-1:0] cycle_cnt_p0, stall_cnt_p0;

  logic active, fetching, hazard, load_use, branch_act, stall_act, halt_live;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  assign load_use = ex_mem_read && (ex_w_addr != '0) &&
                    ((ex_w_addr == id_rs_addr) || (ex_w_addr == id_rt_addr));

`ifdef PIPELINE_FWD_EN
  pipeline_fwd_unit #(
    .REG_ADDR_BITS (REG_ADDR_BITS)
  ) u_fwd (
    .ex_rs_addr    (ex_rs_addr),
    .ex_rt_addr    (ex_rt_addr),
    .mem_w_addr    (mem_w_addr),
    .mem_reg_write (mem_reg_write),
    .wb_w_addr     (wb_w_addr),
    .wb_reg_write  (wb_reg_write),
    .fwd_a_sel     (fwd_a_raw),
    .fwd_b_sel     (fwd_b_raw)
  );

  assign hazard = load_use;

  logic unused_fwd_build;
  assign unused_fwd_build = ex_reg_write;
`else
  // Without forwarding every in-flight producer in EX or MEM blocks its consumer in ID.
  function automatic logic interlock(input logic [REG_ADDR_BITS-1:0] src);
    return (src != '0) &&
           ((ex_reg_write  && (ex_w_addr  == src)) ||
            (mem_reg_write && (mem_w_addr == src)));
  endfunction

  assign fwd_a_raw = FWD_REG;
  assign fwd_b_raw = FWD_REG;
  assign hazard    = load_use || interlock(id_rs_addr) || interlock(id_rt_addr);

  logic unused_nofwd_build;
  assign unused_nofwd_build = ^{ex_rs_addr, ex_rt_addr, wb_w_addr, wb_reg_write};
`endif

  assign active     = (state_p0 == ST_RUN) || (state_p0 == ST_STEP) || (state_p0 == ST_DRAIN);
  assign fetching   = (state_p0 == ST_RUN) || (state_p0 == ST_STEP);
  assign branch_act = active && branch_taken;
  // A taken branch squashes the younger instruction in ID, so it cancels any stall it causes.
  assign stall_act  = active && hazard && !branch_taken;
  // A HALT sitting in ID behind a taken branch is on the wrong path.
  assign halt_live  = id_halt && !branch_taken;

  always_comb begin
    state_d = state_p0;
    case (state_p0)
      ST_IDLE: begin
        if (run)       state_d = ST_RUN;
        else if (step) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (halt_live) state_d = ST_DRAIN;
        else if (!run) state_d = ST_IDLE;
      end
      ST_STEP:   state_d = halt_live ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: begin
        if (branch_taken)                 state_d = ST_RUN;
        else if (drain_cnt_p0 <= DCW'(1)) state_d = ST_HALTED;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign pc_enable    = branch_act || (fetching && !hazard);
  assign if_id_enable = branch_act || (fetching && !hazard);
  assign stage_enable = active;
  assign if_id_flush  = branch_act;
  assign id_ex_flush  = branch_act || stall_act;
  assign ex_mem_flush = branch_act;
  assign fwd_a_sel    = rst_n ? fwd_a_raw : FWD_REG;
  assign fwd_b_sel    = rst_n ? fwd_b_raw : FWD_REG;
  assign halted       = (state_p0 == ST_HALTED);
  assign state_out    = state_p0;
  assign cycle_count  = cycle_cnt_p0;
  assign stall_count  = stall_cnt_p0;

  // ---- p0: FSM, drain down-counter, statistics counters ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0     <= ST_IDLE;
      drain_cnt_p0 <= '0;
      cycle_cnt_p0 <= '0;
      stall_cnt_p0 <= '0;
    end else begin
      state_p0 <= state_d;
      if ((state_d == ST_DRAIN) && (state_p0 != ST_DRAIN))
        drain_cnt_p0 <= DCW'(DRAIN_CYCLES);
      else if ((state_p0 == ST_DRAIN) && (drain_cnt_p0 != '0))
        drain_cnt_p0 <= drain_cnt_p0 - DCW'(1);
      if (active)
        cycle_cnt_p0 <= sat_inc(cycle_cnt_p0);
      if (stall_act)
        stall_cnt_p0 <= sat_inc(stall_cnt_p0);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed self-checking bench for pipeline_ctrl.
// Expectations follow whichever build is compiled (PIPELINE_FWD_EN or not).
module tb_pipeline_ctrl;

`ifdef PIPELINE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run, step, id_halt, branch_taken;
  logic [4:0] id_rs_addr, id_rt_addr, ex_rs_addr, ex_rt_addr;
  logic       ex_mem_read, ex_reg_write, mem_reg_write, wb_reg_write;
  logic [4:0] ex_w_addr, mem_w_addr, wb_w_addr;
  logic       pc_enable, if_id_enable, stage_enable;
  logic       if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       halted;
  logic [2:0] state_out;
  logic [31:0] cycle_count, stall_count;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(
    .REG_ADDR_BITS (5),
    .CNT_WIDTH     (32),
    .DRAIN_CYCLES  (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .step          (step),
    .id_halt       (id_halt),
    .id_rs_addr    (id_rs_addr),
    .id_rt_addr    (id_rt_addr),
    .ex_rs_addr    (ex_rs_addr),
    .ex_rt_addr    (ex_rt_addr),
    .ex_mem_read   (ex_mem_read),
    .ex_w_addr     (ex_w_addr),
    .ex_reg_write  (ex_reg_write),
    .mem_w_addr    (mem_w_addr),
    .mem_reg_write (mem_reg_write),
    .wb_w_addr     (wb_w_addr),
    .wb_reg_write  (wb_reg_write),
    .branch_taken  (branch_taken),
    .pc_enable     (pc_enable),
    .if_id_enable  (if_id_enable),
    .stage_enable  (stage_enable),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_flush  (ex_mem_flush),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel),
    .halted        (halted),
    .state_out     (state_out),
    .cycle_count   (cycle_count),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pipe();
    id_halt = 0; branch_taken = 0;
    id_rs_addr = 0; id_rt_addr = 0; ex_rs_addr = 0; ex_rt_addr = 0;
    ex_mem_read = 0; ex_reg_write = 0; ex_w_addr = 0;
    mem_reg_write = 0; mem_w_addr = 0; wb_reg_write = 0; wb_w_addr = 0;
  endtask

  initial begin
    rst_n = 0; run = 0; step = 0;
    clear_pipe();
    // forwarding match present while held in reset
    mem_reg_write = 1; mem_w_addr = 5; ex_rs_addr = 5;
    cyc(); cyc();
    chk("rst_state", state_out, 3'd0);
    chk("rst_pc", pc_enable, 1'b0);
    chk("rst_stage", stage_enable, 1'b0);
    chk("rst_fwd_a", fwd_a_sel, 2'd0);
    chk("rst_cycles", cycle_count, 32'd0);
    chk("rst_stalls", stall_count, 32'd0);
    clear_pipe();
    rst_n = 1;

    // single step from IDLE
    step = 1; #1;
    chk("idle_pc", pc_enable, 1'b0);
    cyc(); step = 0; #1;
    chk("step_state", state_out, 3'd2);
    chk("step_pc", pc_enable, 1'b1);
    chk("step_stage", stage_enable, 1'b1);
    cyc();
    chk("step_back_idle", state_out, 3'd0);
    chk("step_pc_off", pc_enable, 1'b0);
    chk("step_cycles", cycle_count, 32'd1);

    // RUN: lw $2 in EX, add $3,$2,$4 in ID
    run = 1;
    cyc();
    ex_mem_read = 1; ex_reg_write = 1; ex_w_addr = 2; id_rs_addr = 2; id_rt_addr = 4; #1;
    chk("lu_state", state_out, 3'd1);
    chk("lu_pc", pc_enable, 1'b0);
    chk("lu_ifid_en", if_id_enable, 1'b0);
    chk("lu_idex_flush", id_ex_flush, 1'b1);
    chk("lu_stage", stage_enable, 1'b1);
    cyc();
    // bubble in EX, lw in MEM, add still in ID
    ex_mem_read = 0; ex_reg_write = 0; ex_w_addr = 0; mem_reg_write = 1; mem_w_addr = 2; #1;
    chk("lu_stalls", stall_count, 32'd1);
    chk("post_lu_pc", pc_enable, FWD ? 1'b1 : 1'b0);
    chk("post_lu_flush", id_ex_flush, FWD ? 1'b0 : 1'b1);
    cyc();
    // add in EX, lw in WB
    mem_reg_write = 0; mem_w_addr = 0; wb_reg_write = 1; wb_w_addr = 2;
    ex_rs_addr = 2; ex_rt_addr = 4; ex_reg_write = 1; ex_w_addr = 3;
    id_rs_addr = 0; id_rt_addr = 0; #1;
    chk("fwd_wb_a", fwd_a_sel, FWD ? 2'd1 : 2'd0);
    chk("fwd_wb_b", fwd_b_sel, 2'd0);
    chk("fwd_wb_pc", pc_enable, 1'b1);
    chk("stalls_b", stall_count, FWD ? 32'd1 : 32'd2);

    // add $5 in MEM, sub rs=$5 in EX; WB writes $7 = rt
    ex_rs_addr = 5; ex_rt_addr = 7; mem_reg_write = 1; mem_w_addr = 5;
    wb_reg_write = 1; wb_w_addr = 7; #1;
    chk("fwd_mem_a", fwd_a_sel, FWD ? 2'd2 : 2'd0);
    chk("fwd_wb_rt", fwd_b_sel, FWD ? 2'd1 : 2'd0);
    wb_w_addr = 5; ex_rt_addr = 0; #1;
    chk("fwd_mem_prio", fwd_a_sel, FWD ? 2'd2 : 2'd0);
    chk("fwd_b_none", fwd_b_sel, 2'd0);
    mem_w_addr = 0; ex_rs_addr = 0; #1;
    chk("fwd_zero_dst", fwd_a_sel, 2'd0);

    // branch taken together with load-use
    clear_pipe();
    ex_mem_read = 1; ex_reg_write = 1; ex_w_addr = 2; id_rs_addr = 2; branch_taken = 1; #1;
    chk("br_ifid_flush", if_id_flush, 1'b1);
    chk("br_idex_flush", id_ex_flush, 1'b1);
    chk("br_exmem_flush", ex_mem_flush, 1'b1);
    chk("br_pc", pc_enable, 1'b1);
    cyc();
    clear_pipe(); #1;
    chk("br_stalls", stall_count, FWD ? 32'd1 : 32'd2);
    chk("br_flush_clear", if_id_flush, 1'b0);
    chk("br_cycles", cycle_count, 32'd4);

    // halt in RUN, drain three cycles, then HALTED
    id_halt = 1; #1;
    chk("halt_pc", pc_enable, 1'b1);
    cyc(); id_halt = 0; #1;
    chk("drain1_state", state_out, 3'd3);
    chk("drain1_pc", pc_enable, 1'b0);
    chk("drain1_ifid", if_id_enable, 1'b0);
    chk("drain1_stage", stage_enable, 1'b1);
    cyc();
    chk("drain2_pc", pc_enable, 1'b0);
    chk("drain2_state", state_out, 3'd3);
    cyc();
    chk("drain3_pc", pc_enable, 1'b0);
    chk("drain3_state", state_out, 3'd3);
    cyc();
    chk("halted", halted, 1'b1);
    chk("halted_state", state_out, 3'd4);
    chk("halted_stage", stage_enable, 1'b0);
    chk("halted_cycles", cycle_count, 32'd8);
    step = 1; cyc(); cyc(); step = 0; #1;
    chk("halted_step_ign", state_out, 3'd4);
    chk("halted_frozen", cycle_count, 32'd8);
    chk("halted_pc", pc_enable, 1'b0);

    // reset out of HALTED, then branch during DRAIN
    rst_n = 0; #1;
    chk("rst2_state", state_out, 3'd0);
    chk("rst2_halted", halted, 1'b0);
    chk("rst2_cycles", cycle_count, 32'd0);
    rst_n = 1; run = 1;
    cyc();
    id_halt = 1;
    cyc(); id_halt = 0; branch_taken = 1; #1;
    chk("dbr_state", state_out, 3'd3);
    chk("dbr_pc", pc_enable, 1'b1);
    chk("dbr_ifid_flush", if_id_flush, 1'b1);
    chk("dbr_exmem_flush", ex_mem_flush, 1'b1);
    cyc(); branch_taken = 0; #1;
    chk("dbr_back_run", state_out, 3'd1);
    chk("dbr_cycles", cycle_count, 32'd2);

    // async reset in the middle of DRAIN
    id_halt = 1;
    cyc(); id_halt = 0;
    cyc();
    chk("mid_drain_state", state_out, 3'd3);
    chk("mid_drain_cycles", cycle_count, 32'd4);
    #2;
    mem_reg_write = 1; mem_w_addr = 6; ex_rs_addr = 6;
    rst_n = 0; #1;
    chk("arst_state", state_out, 3'd0);
    chk("arst_stage", stage_enable, 1'b0);
    chk("arst_pc", pc_enable, 1'b0);
    chk("arst_cycles", cycle_count, 32'd0);
    chk("arst_stalls", stall_count, 32'd0);
    chk("arst_fwd_a", fwd_a_sel, 2'd0);
    #1;
    rst_n = 1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Control/hazard block for the parametrised 5-stage pipeline (IF, ID, EX, MEM, WB). Next generation of the top-level pipeline control.
- Replaces the raw external pc_enable with a run/step/halt debug FSM.
- Adds load-use stall, branch flush, EX/MEM and MEM/WB forwarding selects, and saturating cycle/stall counters.
- Sits beside the stage units in the top level, drives every stage-register enable and flush.

Parameters:
- REG_ADDR_BITS, 5, register-file address width.
- CNT_WIDTH, 32, width of cycle_count and stall_count.
- DRAIN_CYCLES, 3, cycles after halt detect until WB retires the last instruction.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; free-run while high.
- step  in  1  pulse; advance exactly one cycle when idle.
- id_halt  in  1  HALT opcode decoded in ID.
- id_rs_addr  in  REG_ADDR_BITS  rs of instruction in ID.
- id_rt_addr  in  REG_ADDR_BITS  rt of instruction in ID.
- ex_rs_addr  in  REG_ADDR_BITS  rs of instruction in EX.
- ex_rt_addr  in  REG_ADDR_BITS  rt of instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_w_addr  in  REG_ADDR_BITS  destination in EX.
- ex_reg_write  in  1  EX writes the register file.
- mem_w_addr  in  REG_ADDR_BITS  destination in MEM.
- mem_reg_write  in  1  MEM writes the register file.
- wb_w_addr  in  REG_ADDR_BITS  destination in WB.
- wb_reg_write  in  1  WB writes the register file.
- branch_taken  in  1  branch resolved taken in MEM.
- pc_enable  out  1  PC update enable.
- if_id_enable  out  1  IF/ID register enable.
- stage_enable  out  1  ID/EX, EX/MEM, MEM/WB enable.
- if_id_flush  out  1  bubble IF/ID.
- id_ex_flush  out  1  bubble ID/EX.
- ex_mem_flush  out  1  bubble EX/MEM.
- fwd_a_sel  out  2  ALU operand A: 0 regfile, 1 MEM/WB, 2 EX/MEM.
- fwd_b_sel  out  2  ALU operand B, same encoding.
- halted  out  1  FSM in HALTED.
- state_out  out  3  FSM state, for debug.
- cycle_count  out  CNT_WIDTH  cycles with stage_enable high.
- stall_count  out  CNT_WIDTH  load-use stall cycles.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all enables and flushes 0; fwd selects 0; halted 0; both counters 0.
  - Counters and FSM register on clk after rst_n deasserts.
- FSM states: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
  - IDLE: run goes to RUN; otherwise step goes to STEP; else stay.
  - RUN: id_halt goes to DRAIN; run low goes to IDLE. id_halt has priority.
  - STEP: lasts exactly one cycle; id_halt goes to DRAIN, else IDLE.
  - DRAIN: pc_enable=0, if_id_enable=0, stage_enable=1. Internal down-counter loaded with DRAIN_CYCLES on entry; reaching 0 goes to HALTED.
  - HALTED: all enables 0; leaves only via reset.
- Active cycle (RUN, STEP, DRAIN) sets stage_enable=1. In RUN and STEP, pc_enable and if_id_enable are 1 unless stalled.
- Load-use stall (combinational):
  - Condition: ex_mem_read, ex_w_addr≠0, and ex_w_addr equal to id_rs_addr or id_rt_addr.
  - Response: pc_enable=0, if_id_enable=0, id_ex_flush=1.
  - stall_count +1 per active stall cycle.
- Branch (combinational, active cycles only): branch_taken sets if_id_flush, id_ex_flush and ex_mem_flush to 1, with pc_enable=1 so the branch target loads.
  - Branch overrides stall.
  - Branch during DRAIN: flush and return to RUN; the halt in the wrong path is squashed.
- Forwarding, operand A:
  - 2 if mem_reg_write, mem_w_addr≠0 and mem_w_addr=ex_rs_addr.
  - Else 1 if the same conditions hold for the wb_* signals.
  - Else 0.
- Forwarding, operand B: same rules against ex_rt_addr.
- Inactive states: all flushes 0 and counters hold.
- Counters saturate at all-ones, no wrap.

Optional Feature:
- Macro: PIPELINE_FWD_EN.
- Defined: forwarding as above.
- Undefined:
  - fwd_a_sel and fwd_b_sel are tied to 0.
  - Full interlock: stall (same response as load-use) whenever an ID source (≠0) matches ex_w_addr with ex_reg_write, or mem_w_addr with mem_reg_write.
  - stall_count counts these stalls.

Decomposition:
- Shared package pipeline_pkg:
  - state encoding constants.
  - forwarding select constants FWD_REG, FWD_WB, FWD_MEM.
  - REG_ADDR_BITS default.
- One natural sub-module: pipeline_fwd_unit, the combinational forwarding compare, instantiated only under PIPELINE_FWD_EN.

Test Plan:
- Reset, then step pulse from IDLE: exactly one cycle with pc_enable=1 and stage_enable=1; state_out returns to 0; cycle_count=1.
- RUN with `lw $2` in EX and `add $3,$2,$4` in ID: one cycle with pc_enable=0 and id_ex_flush=1; stall_count=1; next cycle fwd_a_sel=1.
- `add $5` in MEM and `sub` with rs=$5 in EX: fwd_a_sel=2. Same with $0 destination: fwd_a_sel=0.
- branch_taken and load-use in the same cycle: all three flushes 1, pc_enable=1, stall_count unchanged.
- id_halt in RUN: pc_enable=0 for the next 3 cycles, then halted=1 and cycle_count frozen. A step pulse is ignored.
- rst_n pulled low mid-DRAIN: outputs go to reset values immediately, without waiting for a clk edge.
